// File: rtl/lcm_pkg.sv
// Shared definitions for the GCD/LCM engine: controller states, mode encoding
// and the width helper for the common-factor-of-two counter.
package lcm_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GCD,
      S_DIV,
      S_MUL,
      S_DONE
   } state_t;

   localparam logic MODE_LCM = 1'b0;
   localparam logic MODE_GCD = 1'b1;

   // k counts shared factors of two and can reach WIDTH, so it needs clog2(WIDTH+1) bits
   function automatic int gcd_kw(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/lcm_seq_unit_if.sv
// Command/result handshake bundle of the GCD/LCM engine; master drives
// operands and accepts results, slave is the engine.
interface lcm_seq_unit_if #(
   parameter int WIDTH = 32
);

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_a;
   logic [WIDTH-1:0]     in_b;
   logic                 in_mode;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     gcd_out;
   logic [2*WIDTH-1:0]   lcm_out;
   logic                 busy;

   modport master (
      output in_valid, in_a, in_b, in_mode, out_ready,
      input  in_ready, out_valid, gcd_out, lcm_out, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, in_mode, out_ready,
      output in_ready, out_valid, gcd_out, lcm_out, busy
   );

endinterface

// File: rtl/binary_gcd_core.sv
// Binary (Stein) GCD engine: loads on start, performs one reduction step per
// cycle while run is high, and flags done combinationally once u or v hits zero.
module binary_gcd_core
   import lcm_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             run,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] g
);

   localparam int KW = gcd_kw(WIDTH);

   logic [WIDTH-1:0] u;
   logic [WIDTH-1:0] v;
   logic [KW-1:0]    k;
   logic [WIDTH-1:0] odd_part;

   assign done     = run && ((u == '0) || (v == '0));
   assign odd_part = (u == '0) ? v : u;
   assign g        = odd_part << k;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         u <= '0;
         v <= '0;
         k <= '0;
      end else if (start) begin
         u <= a;
         v <= b;
         k <= '0;
      end else if (run && !done) begin
         if (!u[0] && !v[0]) begin
            u <= u >> 1;
            v <= v >> 1;
            k <= k + 1'b1;
         end else if (!u[0]) begin
            u <= u >> 1;
         end else if (!v[0]) begin
            v <= v >> 1;
         end else if (u >= v) begin
            // both odd: the difference is even, so halve it in the same step
            u <= (u - v) >> 1;
         end else begin
            v <= (v - u) >> 1;
         end
      end
   end

endmodule

// File: rtl/lcm_seq_unit.sv
// Multi-cycle GCD/LCM engine: Stein GCD, then bit-serial exact division a/g
// and shift-add multiply (a/g)*b giving the full 2*WIDTH-bit LCM.
module lcm_seq_unit
   import lcm_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   lcm_seq_unit_if.slave      bus
);

   localparam int CW = $clog2(WIDTH);

   state_t             state;
   state_t             state_next;

   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [WIDTH-1:0]   g_reg;
   logic               mode_reg;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   gcd_q;
   logic [2*WIDTH-1:0] lcm_q;

   logic               accept;
   logic               zero_op;
   logic               core_done;
   logic [WIDTH-1:0]   core_g;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     rem_diff;
   logic               rem_ge;
   logic [2*WIDTH-1:0] acc_next;

   assign accept  = bus.in_valid && (state == S_IDLE);
   assign zero_op = (bus.in_a == '0) || (bus.in_b == '0);

   binary_gcd_core #(.WIDTH(WIDTH)) u_gcd (
      .clk   (clk),
      .rst   (rst),
      .start (accept && !zero_op),
      .run   (state == S_GCD),
      .a     (bus.in_a),
      .b     (bus.in_b),
      .done  (core_done),
      .g     (core_g)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next    = state;
      bus.in_ready  = (state == S_IDLE);
      bus.busy      = (state != S_IDLE);
      bus.out_valid = (state == S_DONE);
      case (state)
         S_IDLE: if (bus.in_valid) state_next = zero_op ? S_DONE : S_GCD;
         S_GCD:  if (core_done) state_next = (mode_reg == MODE_GCD) ? S_DONE : S_DIV;
         S_DIV:  if (cnt == '0) state_next = S_MUL;
         S_MUL:  if (cnt == '0) state_next = S_DONE;
         S_DONE: if (bus.out_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // no borrow out of the trial subtraction means the shifted remainder covers g
   assign rem_shift = {rem, quo[WIDTH-1]};
   assign rem_diff  = rem_shift - {1'b0, g_reg};
   assign rem_ge    = !rem_diff[WIDTH];
   assign acc_next  = (acc << 1) + (quo[WIDTH-1] ? {{WIDTH{1'b0}}, b_reg} : '0);

   assign bus.gcd_out = gcd_q;
   assign bus.lcm_out = lcm_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg    <= '0;
         b_reg    <= '0;
         g_reg    <= '0;
         mode_reg <= MODE_LCM;
         quo      <= '0;
         rem      <= '0;
         acc      <= '0;
         cnt      <= '0;
         gcd_q    <= '0;
         lcm_q    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  a_reg    <= bus.in_a;
                  b_reg    <= bus.in_b;
                  mode_reg <= bus.in_mode;
                  if (zero_op) begin
                     gcd_q <= bus.in_a | bus.in_b;
                     lcm_q <= '0;
                  end
               end
            end
            S_GCD: begin
               if (core_done) begin
                  g_reg <= core_g;
                  if (mode_reg == MODE_GCD) begin
                     gcd_q <= core_g;
                     lcm_q <= '0;
                  end else begin
                     quo <= a_reg;
                     rem <= '0;
                     cnt <= CW'(WIDTH - 1);
                  end
               end
            end
            S_DIV: begin
               quo <= {quo[WIDTH-2:0], rem_ge};
               rem <= rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
               if (cnt == '0) begin
                  cnt <= CW'(WIDTH - 1);
                  acc <= '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_MUL: begin
               // quotient bits are consumed MSB first, accumulator doubles each step
               acc <= acc_next;
               quo <= quo << 1;
               if (cnt == '0) begin
                  gcd_q <= g_reg;
                  lcm_q <= acc_next;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lcm_seq_unit.sv
// Self-checking bench for lcm_seq_unit: directed corner jobs plus randomized
// jobs compared against an arithmetic GCD/LCM and latency reference model.
module tb_lcm_seq_unit;
   import lcm_pkg::*;

   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 400;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   lcm_seq_unit_if #(.WIDTH(WIDTH)) bus ();

   lcm_seq_unit #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Euclid's algorithm, independent of the hardware's binary method
   function automatic longint unsigned refGcd(input longint unsigned a, input longint unsigned b);
      longint unsigned x = a;
      longint unsigned y = b;
      longint unsigned t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   function automatic longint unsigned refLcm(input longint unsigned a, input longint unsigned b,
                                              input logic mode);
      if (mode == MODE_GCD || a == 0 || b == 0) return 0;
      return (a / refGcd(a, b)) * b;
   endfunction

   // number of GCD-state cycles the stepping rules take, including the exit cycle
   function automatic int refSteps(input longint unsigned a, input longint unsigned b);
      longint unsigned u = a;
      longint unsigned v = b;
      int n = 0;
      while (n < 1000) begin
         n++;
         if (u == 0 || v == 0) return n;
         if (u % 2 == 0 && v % 2 == 0) begin u = u / 2; v = v / 2; end
         else if (u % 2 == 0) u = u / 2;
         else if (v % 2 == 0) v = v / 2;
         else if (u >= v) u = (u - v) / 2;
         else v = (v - u) / 2;
      end
      return n;
   endfunction

   function automatic int refLatency(input longint unsigned a, input longint unsigned b,
                                     input logic mode);
      if (a == 0 || b == 0) return 1;
      return 1 + refSteps(a, b) + ((mode == MODE_GCD) ? 0 : 2 * WIDTH);
   endfunction

   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic mode, output int lat);
      @(negedge clk);
      checkOutput("in_ready_idle", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_mode  = mode;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_a     = $urandom;
      bus.in_b     = $urandom;
      checkOutput("busy_after_accept", 64'(bus.busy), 64'd1);
      lat = 1;
      while (!bus.out_valid && lat < TIMEOUT) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic checkResult(input string tag, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b, input logic mode, input int lat);
      checkOutput({tag, "_gcd"}, 64'(bus.gcd_out), refGcd(64'(a), 64'(b)));
      checkOutput({tag, "_lcm"}, bus.lcm_out, refLcm(64'(a), 64'(b), mode));
      checkOutput({tag, "_latency"}, 64'(lat), 64'(refLatency(64'(a), 64'(b), mode)));
   endtask

   task automatic acceptResult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic mode);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      checkOutput("out_valid_drop", 64'(bus.out_valid), 64'd0);
      checkOutput("in_ready_back", 64'(bus.in_ready), 64'd1);
      checkOutput("busy_idle", 64'(bus.busy), 64'd0);
      checkOutput("gcd_hold_idle", 64'(bus.gcd_out), refGcd(64'(a), 64'(b)));
      checkOutput("lcm_hold_idle", bus.lcm_out, refLcm(64'(a), 64'(b), mode));
   endtask

   task automatic runJob(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic mode);
      int lat;
      applyStimulus(a, b, mode, lat);
      checkResult(tag, a, b, mode, lat);
      acceptResult(a, b, mode);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
      checkOutput({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd0);
      checkOutput({tag, "_gcd"}, 64'(bus.gcd_out), 64'd0);
      checkOutput({tag, "_lcm"}, bus.lcm_out, 64'd0);
   endtask

   logic [WIDTH-1:0] dir_a [9];
   logic [WIDTH-1:0] dir_b [9];
   logic             dir_m [9];

   initial begin
      int lat;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rm;

      checks        = 0;
      errors        = 0;
      clk           = 1'b0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_mode   = MODE_LCM;
      bus.out_ready = 1'b0;

      dir_a = '{32'd12, 32'd0, 32'd0, 32'hFFFFFFFF, 32'h80000000, 32'd48, 32'd1, 32'd77777, 32'd5};
      dir_b = '{32'd18, 32'd5, 32'd0, 32'hFFFFFFFE, 32'h80000000, 32'd180, 32'hDEADBEEF, 32'd77777, 32'd0};
      dir_m = '{MODE_LCM, MODE_LCM, MODE_LCM, MODE_LCM, MODE_LCM, MODE_GCD, MODE_LCM, MODE_LCM, MODE_GCD};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkResetState("reset");

      for (int i = 0; i < 9; i++) runJob($sformatf("dir%0d", i), dir_a[i], dir_b[i], dir_m[i]);

      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 3))
            0: begin ra = $urandom; rb = $urandom; end
            1: begin ra = WIDTH'($urandom_range(0, 15)); rb = WIDTH'($urandom_range(0, 15)); end
            2: begin
               ra = WIDTH'($urandom_range(1, 65535)) << $urandom_range(0, 12);
               rb = WIDTH'($urandom_range(1, 65535)) << $urandom_range(0, 12);
            end
            default: begin ra = $urandom; rb = ra; end
         endcase
         rm = 1'($urandom_range(0, 1));
         runJob($sformatf("rnd%0d", i), ra, rb, rm);
      end

      // result held in DONE while the consumer stalls; new commands are ignored
      applyStimulus(32'd100, 32'd75, MODE_LCM, lat);
      checkResult("stall", 32'd100, 32'd75, MODE_LCM, lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_a     = 32'd9;
         bus.in_b     = 32'd6;
         @(posedge clk);
         #1;
         checkOutput("stall_out_valid", 64'(bus.out_valid), 64'd1);
         checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
         checkOutput("stall_gcd", 64'(bus.gcd_out), 64'd25);
         checkOutput("stall_lcm", bus.lcm_out, 64'd300);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      acceptResult(32'd100, 32'd75, MODE_LCM);

      // abort in the middle of the multiply phase
      ra = 32'hC0FFEE11;
      rb = 32'h12345678;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a     = ra;
      bus.in_b     = rb;
      bus.in_mode  = MODE_LCM;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (refSteps(64'(ra), 64'(rb)) + WIDTH + WIDTH / 2) @(posedge clk);
      #1;
      checkOutput("mid_mul_busy", 64'(bus.busy), 64'd1);
      checkOutput("mid_mul_out_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkResetState("abort");
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkResetState("abort_release");
      runJob("after_abort", 32'd60, 32'd52, MODE_LCM);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
